// File: rtl/directcache_pkg.sv
// Shared types and helpers for the parametrised direct-mapped read cache.
package directcache_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FLUSH   = 3'd1,
    IDLE    = 3'd2,
    LOOKUP  = 3'd3,
    WRMERGE = 3'd4,
    FILL    = 3'd5
  } state_t;

  // Address bits above the cached region, i.e. what the tag RAM must hold.
  function automatic int tag_width(input int addrbits, input int cachebits);
    return addrbits - cachebits - 2;
  endfunction

  // Number of tag RAM address bits (one tag per line).
  function automatic int index_width(input int cachebits, input int linebits);
    return cachebits - linebits;
  endfunction

  // Overlay the enabled bytes of new_word onto old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/direct_cache_ram.sv
// Single-port synchronous RAM with registered output; a write also
// presents the written word on q (write-first).
module direct_cache_ram #(
  parameter int ADDRBITS_RAM = 8,
  parameter int WIDTH        = 32
) (
  input  logic                    clk,
  input  logic [ADDRBITS_RAM-1:0] addr,
  input  logic                    we,
  input  logic [WIDTH-1:0]        d,
  output logic [WIDTH-1:0]        q
);

  logic [WIDTH-1:0] mem [0:(1 << ADDRBITS_RAM) - 1];

  // One-cycle read, write-first on the same port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= d;
      q         <= d;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/direct_cache_param.sv
// Parametrised direct-mapped read cache between the CPU and a burst SDRAM
// controller. Read misses fill a whole line critical-word-first; write hits
// merge bytes into the cached line; write misses do not allocate.
// Optional hit/miss counters are built when DIRECTCACHE_STATS_EN is defined.
module direct_cache_param
  import directcache_pkg::*;
#(
  parameter int CACHEBITS = 11,
  parameter int LINEBITS  = 3,
  parameter int ADDRBITS  = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic                cpu_req,
  input  logic                cpu_rw,
  input  logic [3:0]          bytesel,
  input  logic [31:0]         data_from_cpu,
  output logic [31:0]         data_to_cpu,
  output logic                cpu_ack,
  output logic [ADDRBITS-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_fill,
  input  logic [31:0]         data_from_sdram,
  output logic                busy,
  input  logic                flush
`ifdef DIRECTCACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int TAGW = tag_width(ADDRBITS, CACHEBITS);
  localparam int IDXW = index_width(CACHEBITS, LINEBITS);

  state_t              state;
  logic [IDXW-1:0]     flush_cnt;
  logic                flushpending;
  logic [LINEBITS-1:0] fill_off;
  logic [LINEBITS-1:0] fill_cnt;

  logic [ADDRBITS-1:0] addr_l;
  logic [31:0]         wdata_l;
  logic [3:0]          bytesel_l;
  logic                rw_l;

  logic [IDXW-1:0]     tag_addr;
  logic                tag_we;
  logic [TAGW:0]       tag_d;
  logic [TAGW:0]       tag_q;
  logic [CACHEBITS-1:0] data_addr;
  logic                data_we;
  logic [31:0]         data_d;
  logic [31:0]         data_q;

  logic                accept;
  logic                hit;

  // The ack cycle still sees cpu_req high, so it must not start a new access.
  assign accept     = (state == IDLE) && !flushpending && cpu_req && !cpu_ack;
  assign hit        = (tag_q == {1'b1, addr_l[ADDRBITS-1:CACHEBITS+2]});
  assign busy       = (state != IDLE);
  assign sdram_addr = addr_l;

  // RAM address/write steering: IDLE looks up the live CPU address so the
  // RAM outputs are ready in LOOKUP; other states use the latched address.
  always_comb begin
    tag_addr  = addr_l[CACHEBITS+1:LINEBITS+2];
    tag_we    = 1'b0;
    tag_d     = {1'b1, addr_l[ADDRBITS-1:CACHEBITS+2]};
    data_addr = addr_l[CACHEBITS+1:2];
    data_we   = 1'b0;
    data_d    = byte_merge(data_q, wdata_l, bytesel_l);
    case (state)
      INIT, FLUSH: begin
        tag_addr = flush_cnt;
        tag_we   = 1'b1;
        tag_d    = '0;
      end
      IDLE: begin
        tag_addr  = cpu_addr[CACHEBITS+1:LINEBITS+2];
        data_addr = cpu_addr[CACHEBITS+1:2];
      end
      LOOKUP:  tag_we = rw_l && !hit;
      WRMERGE: data_we = 1'b1;
      FILL: begin
        data_addr = {addr_l[CACHEBITS+1:LINEBITS+2], fill_off};
        data_we   = sdram_fill;
        data_d    = data_from_sdram;
      end
      default: ;
    endcase
  end

  // Capture the CPU request when it is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_l    <= cpu_addr;
      wdata_l   <= data_from_cpu;
      bytesel_l <= bytesel;
      rw_l      <= cpu_rw;
    end
  end

  // Control FSM: invalidate sweep, lookup, write merge and line fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= INIT;
      flush_cnt    <= '0;
      flushpending <= 1'b0;
      fill_off     <= '0;
      fill_cnt     <= '0;
      ready        <= 1'b0;
      cpu_ack      <= 1'b0;
      sdram_req    <= 1'b0;
      data_to_cpu  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (flush) flushpending <= 1'b1;
      case (state)
        INIT, FLUSH: begin
          if (&flush_cnt) begin
            flush_cnt <= '0;
            ready     <= 1'b1;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + IDXW'(1);
            state     <= FLUSH;
          end
        end
        IDLE: begin
          if (flushpending) begin
            flushpending <= flush;
            state        <= FLUSH;
          end else if (accept) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rw_l) begin
            if (hit) begin
              data_to_cpu <= data_q;
              cpu_ack     <= 1'b1;
              state       <= IDLE;
            end else begin
              sdram_req <= 1'b1;
              fill_off  <= addr_l[LINEBITS+1:2];
              fill_cnt  <= '0;
              state     <= FILL;
            end
          end else if (hit) begin
            state <= WRMERGE;
          end else begin
            cpu_ack <= 1'b1;
            state   <= IDLE;
          end
        end
        WRMERGE: begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        FILL: begin
          if (sdram_fill) begin
            fill_off <= fill_off + LINEBITS'(1);
            fill_cnt <= fill_cnt + LINEBITS'(1);
            if (fill_cnt == '0) begin
              sdram_req   <= 1'b0;
              data_to_cpu <= data_from_sdram;
              cpu_ack     <= 1'b1;
            end
            if (&fill_cnt) state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef DIRECTCACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Read hit/miss counters, cleared by reset and when a flush starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && flushpending) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP && rw_l) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  direct_cache_ram #(
    .ADDRBITS_RAM(IDXW),
    .WIDTH       (TAGW + 1)
  ) u_tag_ram (
    .clk (clk),
    .addr(tag_addr),
    .we  (tag_we),
    .d   (tag_d),
    .q   (tag_q)
  );

  direct_cache_ram #(
    .ADDRBITS_RAM(CACHEBITS),
    .WIDTH       (32)
  ) u_data_ram (
    .clk (clk),
    .addr(data_addr),
    .we  (data_we),
    .d   (data_d),
    .q   (data_q)
  );

endmodule

// File: tb/tb_direct_cache_param.sv
// Directed bench for direct_cache_param with default geometry
// (CACHEBITS=11, LINEBITS=3): 256 lines of 8 words.
module tb_direct_cache_param;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_rw;
  logic [3:0]  bytesel;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        cpu_ack;
  logic [31:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_fill;
  logic [31:0] data_from_sdram;
  logic        busy;
  logic        flush;

  int tests  = 0;
  int failed = 0;

  direct_cache_param dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .cpu_addr       (cpu_addr),
    .cpu_req        (cpu_req),
    .cpu_rw         (cpu_rw),
    .bytesel        (bytesel),
    .data_from_cpu  (data_from_cpu),
    .data_to_cpu    (data_to_cpu),
    .cpu_ack        (cpu_ack),
    .sdram_addr     (sdram_addr),
    .sdram_req      (sdram_req),
    .sdram_fill     (sdram_fill),
    .data_from_sdram(data_from_sdram),
    .busy           (busy),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue a read expected to miss; sdram_req must appear 2 edges later.
  task automatic start_miss(input logic [31:0] addr);
    int n;
    cpu_addr = addr;
    cpu_rw   = 1'b1;
    cpu_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sdram_req && n < 20);
    check("miss_req_latency", n, 2);
    check("miss_sdram_addr", sdram_addr, addr);
  endtask

  // Present fill word i of a burst whose words are {4{base+i}}.
  task automatic fill_word(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(i);
    sdram_fill      = 1'b1;
    data_from_sdram = {4{b}};
    tick();
    if (i == 0) begin
      check("fill_first_ack", cpu_ack, 1);
      check("fill_first_data", data_to_cpu, {4{base}});
      check("fill_req_dropped", sdram_req, 0);
      cpu_req = 1'b0;
    end else if (i == 1) begin
      check("fill_second_noack", cpu_ack, 0);
    end
  endtask

  task automatic end_fill();
    sdram_fill      = 1'b0;
    data_from_sdram = '0;
  endtask

  task automatic read_miss(input logic [31:0] addr, input logic [7:0] base);
    start_miss(addr);
    for (int i = 0; i < 8; i++) fill_word(base, i);
    end_fill();
  endtask

  // Read expected to hit: ack exactly 2 edges after the request is sampled.
  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr;
    cpu_rw   = 1'b1;
    cpu_req  = 1'b1;
    tick();
    check("hit_no_early_ack", cpu_ack, 0);
    tick();
    check("hit_ack", cpu_ack, 1);
    check("hit_data", data_to_cpu, exp);
    check("hit_no_sdram", sdram_req, 0);
    cpu_req = 1'b0;
    tick();
    check("hit_ack_single", cpu_ack, 0);
  endtask

  task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, input bit expect_hit);
    cpu_addr      = addr;
    cpu_rw        = 1'b0;
    data_from_cpu = data;
    bytesel       = sel;
    cpu_req       = 1'b1;
    tick();
    tick();
    if (expect_hit) begin
      check("wr_hit_no_early_ack", cpu_ack, 0);
      tick();
    end
    check("wr_ack", cpu_ack, 1);
    check("wr_no_sdram", sdram_req, 0);
    cpu_req = 1'b0;
    cpu_rw  = 1'b1;
    bytesel = '0;
    tick();
  endtask

  initial begin
    reset           = 1'b0;
    cpu_addr        = '0;
    cpu_req         = 1'b0;
    cpu_rw          = 1'b1;
    bytesel         = '0;
    data_from_cpu   = '0;
    sdram_fill      = 1'b0;
    data_from_sdram = '0;
    flush           = 1'b0;

    // Reset values, then the 256-cycle invalidate sweep.
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 1);
    check("rst_ack", cpu_ack, 0);
    check("rst_sdram_req", sdram_req, 0);
    check("rst_data", data_to_cpu, 0);
    reset = 1'b1;
    repeat (255) tick();
    check("init_ready_at_255", ready, 0);
    check("init_busy_at_255", busy, 1);
    tick();
    check("init_ready_at_256", ready, 1);
    check("init_idle", busy, 0);

    // Cold miss, critical word at offset 5; line words A0..A7 from offset 5.
    read_miss(32'h0000_1014, 8'hA0);
    read_hit(32'h0000_1000, 32'hA3A3A3A3);

    // Write hit merges bytes 0 and 2.
    write_req(32'h0000_1004, 32'h11223344, 4'b0101, 1'b1);
    read_hit(32'h0000_1004, 32'hA422A444);

    // Write miss on the same index with another tag: acked, not allocated.
    write_req(32'h0000_5000, 32'hDEADBEEF, 4'b1111, 1'b0);
    read_hit(32'h0000_1000, 32'hA3A3A3A3);

    // Conflict eviction on index 0x80.
    read_miss(32'h0000_3000, 8'hB0);
    read_miss(32'h0000_1000, 8'hC0);
    read_hit(32'h0000_101C, 32'hC7C7C7C7);

    // Flush pulse during a fill: the fill completes, then the sweep runs.
    start_miss(32'h0000_2040);
    fill_word(8'hE0, 0);
    flush = 1'b1;
    fill_word(8'hE0, 1);
    flush = 1'b0;
    for (int i = 2; i < 8; i++) fill_word(8'hE0, i);
    end_fill();
    check("flush_fill_done_idle", busy, 0);
    tick();
    check("flush_busy", busy, 1);
    check("flush_ready_kept", ready, 1);
    repeat (255) tick();
    check("flush_busy_at_255", busy, 1);
    tick();
    check("flush_done_idle", busy, 0);
    check("flush_done_ready", ready, 1);
    read_miss(32'h0000_1000, 8'hD0);

    // Reset while sdram_req is pending drops it on the next edge.
    start_miss(32'h0000_2000);
    cpu_req = 1'b0;
    reset   = 1'b0;
    tick();
    check("rstreq_sdram_req", sdram_req, 0);
    check("rstreq_ready", ready, 0);
    check("rstreq_busy", busy, 1);
    reset = 1'b1;
    repeat (256) tick();
    check("rstreq_reinit_ready", ready, 1);

    // Reset on the third fill word.
    start_miss(32'h0000_3004);
    fill_word(8'hF0, 0);
    fill_word(8'hF0, 1);
    sdram_fill      = 1'b1;
    data_from_sdram = 32'hF2F2F2F2;
    reset           = 1'b0;
    tick();
    end_fill();
    check("rstfill_sdram_req", sdram_req, 0);
    check("rstfill_no_ack", cpu_ack, 0);
    check("rstfill_ready", ready, 0);
    reset = 1'b1;
    repeat (255) tick();
    check("rstfill_ready_at_255", ready, 0);
    tick();
    check("rstfill_ready_at_256", ready, 1);

    // Everything cached earlier is invalid again.
    read_miss(32'h0000_1000, 8'h90);
    read_hit(32'h0000_1018, 32'h96969696);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
